btn_reader: RTL and testbench

BTN_READER -- requirements
Module: btn_reader

---
 rtl/btn_reader_pkg.sv | 13 +
 rtl/btn_reader_ch.sv | 121 ++++++++++++
 rtl/btn_reader.sv | 34 +++
 tb/tb_btn_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_reader_pkg.sv
// Shared types and constants for the debounced button reader.
package btn_reader_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    Idle,
    PressChk,
    Held,
    ReleaseChk
  } btn_state_e;

endpackage

// File: rtl/btn_reader_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, hold timer for long-press detection.
module btn_reader_ch
  import btn_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_T = 1000 * 1000,
  parameter int unsigned LONG_T     = 50 * 1000 * 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o
);

  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_T - 1);
  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_T - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic             sync1_q, s_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             long_done_q, long_done_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    hcnt_d      = hcnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    unique case (state_q)
      Idle: begin
        if (s_q) begin
          state_d = PressChk;
          dcnt_d  = '0;
        end
      end
      PressChk: begin
        if (!s_q) begin
          state_d = Idle;
        end else if (dcnt_q == DbLast) begin
          state_d     = Held;
          level_d     = 1'b1;
          press_d     = 1'b1;
          hcnt_d      = '0;
          long_done_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + CntOne;
        end
      end
      Held: begin
        // Saturated hold counter arms a single long-press pulse per accepted press.
        if (hcnt_q == LongLast) begin
          if (!long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + CntOne;
        end
        if (!s_q) begin
          state_d = ReleaseChk;
          dcnt_d  = '0;
        end
      end
      ReleaseChk: begin
        if (s_q) begin
          state_d = Held;
        end else if (dcnt_q == DbLast) begin
          state_d   = Idle;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CntOne;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      s_q         <= 1'b0;
      state_q     <= Idle;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      s_q         <= sync1_q;
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;

endmodule

// File: rtl/btn_reader.sv
// W independent debounced button channels with press, release and long-press pulses.
module btn_reader
  import btn_reader_pkg::*;
#(
  parameter int unsigned W          = 3,
  parameter int unsigned DEBOUNCE_T = 1000 * 1000,
  parameter int unsigned LONG_T     = 50 * 1000 * 1000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] btn,
  output logic [W-1:0] level,
  output logic [W-1:0] press,
  // "release" is a reserved word, hence the suffix.
  output logic [W-1:0] release_pulse,
  output logic [W-1:0] long_press
);

  for (genvar i = 0; i < W; i++) begin : g_ch
    btn_reader_ch #(
      .DEBOUNCE_T(DEBOUNCE_T),
      .LONG_T    (LONG_T)
    ) u_ch (
      .clk_i       (clk),
      .rst_ni      (resetn),
      .btn_i       (btn[i]),
      .level_o     (level[i]),
      .press_o     (press[i]),
      .release_o   (release_pulse[i]),
      .long_press_o(long_press[i])
    );
  end

endmodule

// File: tb/tb_btn_reader.sv
// Self-checking bench for btn_reader: directed scenarios plus random stimulus against a run-length model.
module tb_btn_reader;

  localparam int unsigned W  = 3;
  localparam int unsigned DB = 4;
  localparam int unsigned LT = 20;

  logic         clk;
  logic         resetn;
  logic [W-1:0] btn;
  logic [W-1:0] level, press, release_pulse, long_press;

  int n_checks = 0;
  int n_errors = 0;

  btn_reader #(
    .W         (W),
    .DEBOUNCE_T(DB),
    .LONG_T    (LT)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .btn          (btn),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: level flips once the synchronized input has disagreed with it for DB+1
  // consecutive samples; long press fires after LT settled-pressed cycles, once per press.
  logic [W-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long, m_fired;
  int unsigned  m_run  [W];
  int unsigned  m_hold [W];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_s1 <= '0; m_s2 <= '0; m_level <= '0; m_press <= '0;
      m_rel <= '0; m_long <= '0; m_fired <= '0;
      for (int i = 0; i < W; i++) begin
        m_run[i]  <= 0;
        m_hold[i] <= 0;
      end
    end else begin
      m_s1 <= btn;
      m_s2 <= m_s1;
      for (int i = 0; i < W; i++) begin
        m_press[i] <= 1'b0;
        m_rel[i]   <= 1'b0;
        m_long[i]  <= 1'b0;
        if (m_level[i] && m_run[i] == 0) begin
          if (m_hold[i] == LT - 1 && !m_fired[i]) begin
            m_long[i]  <= 1'b1;
            m_fired[i] <= 1'b1;
          end
          m_hold[i] <= (m_hold[i] + 1 > LT - 1) ? LT - 1 : m_hold[i] + 1;
        end
        if (m_s2[i] == m_level[i]) begin
          m_run[i] <= 0;
        end else if (m_run[i] == DB) begin
          m_run[i]   <= 0;
          m_level[i] <= ~m_level[i];
          if (!m_level[i]) begin
            m_press[i] <= 1'b1;
            m_hold[i]  <= 0;
            m_fired[i] <= 1'b0;
          end else begin
            m_rel[i] <= 1'b1;
          end
        end else begin
          m_run[i] <= m_run[i] + 1;
        end
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    btn    = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({level, press, release_pulse, long_press} !== 12'h000) begin
        n_errors++;
        $display("FAIL reset k=%0d: got %b expected %b", k,
                 {level, press, release_pulse, long_press}, 12'h000);
      end
    end
    btn = 3'b000;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_clean_press();
    int press_at = -1, rel_at = -1, n_press = 0, n_rel = 0;
    btn = 3'b001;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({level, press, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        n_errors++;
        $display("FAIL clean_press_model k=%0d: got %b expected %b", k,
                 {level, press, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
      if (press[0]) begin n_press++; press_at = k; end
      if (release_pulse[0]) begin n_rel++; rel_at = k; end
      if (k == 12) btn = 3'b000;
    end
    n_checks++;
    if (press_at != 7 || rel_at != 19 || n_press != 1 || n_rel != 1) begin
      n_errors++;
      $display("FAIL clean_press_timing: got press@%0d x%0d release@%0d x%0d expected press@7 x1 release@19 x1",
               press_at, n_press, rel_at, n_rel);
    end
  endtask

  task automatic test_glitch();
    int n_press = 0, lvl_seen = 0;
    btn = 3'b010;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 3) btn = 3'b000;
      if (press[1]) n_press++;
      if (level[1]) lvl_seen++;
      n_checks++;
      if ({level, press, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        n_errors++;
        $display("FAIL glitch_model k=%0d: got %b expected %b", k,
                 {level, press, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
    end
    n_checks++;
    if (n_press != 0 || lvl_seen != 0) begin
      n_errors++;
      $display("FAIL glitch: got presses=%0d level_cycles=%0d expected 0 and 0", n_press, lvl_seen);
    end
  endtask

  task automatic test_long_press();
    int press_at = -1, long_at = -1, n_long = 0;
    btn = 3'b100;
    for (int k = 1; k <= 56; k++) begin
      @(posedge clk); #1;
      if (press[2]) press_at = k;
      if (long_press[2]) begin n_long++; long_at = k; end
      n_checks++;
      if ({level, press, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        n_errors++;
        $display("FAIL long_model k=%0d: got %b expected %b", k,
                 {level, press, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
      if (k == 40) btn = 3'b000;
    end
    n_checks++;
    if (press_at != 7 || long_at != 27 || n_long != 1) begin
      n_errors++;
      $display("FAIL long_press: got press@%0d long@%0d x%0d expected press@7 long@27 x1",
               press_at, long_at, n_long);
    end
  endtask

  task automatic test_release_bounce();
    int n_press = 0, n_rel = 0, lvl_drop = 0;
    btn = 3'b001;
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk); #1;
      if (press[0]) n_press++;
      if (release_pulse[0]) n_rel++;
      if (k >= 7 && !level[0]) lvl_drop++;
      n_checks++;
      if ({level, press, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        n_errors++;
        $display("FAIL bounce_model k=%0d: got %b expected %b", k,
                 {level, press, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
      if (k == 10) btn = 3'b000;
      if (k == 12) btn = 3'b001;
    end
    n_checks++;
    if (n_press != 1 || n_rel != 0 || lvl_drop != 0) begin
      n_errors++;
      $display("FAIL release_bounce: got presses=%0d releases=%0d level_drops=%0d expected 1 0 0",
               n_press, n_rel, lvl_drop);
    end
    btn = 3'b000;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_hold();
    int p0 = -1, p2 = -1, n_rel = 0;
    btn = 3'b101;
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if (level !== 3'b101) begin
      n_errors++;
      $display("FAIL mid_reset_pre: got level %b expected %b", level, 3'b101);
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({level, press, release_pulse, long_press} !== 12'h000) begin
      n_errors++;
      $display("FAIL mid_reset_async: got %b expected %b",
               {level, press, release_pulse, long_press}, 12'h000);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (release_pulse != 0) n_rel++;
    end
    resetn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (press[0]) p0 = k;
      if (press[2]) p2 = k;
      if (release_pulse != 0) n_rel++;
      n_checks++;
      if ({level, press, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        n_errors++;
        $display("FAIL mid_reset_model k=%0d: got %b expected %b", k,
                 {level, press, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
    end
    n_checks++;
    if (p0 != 7 || p2 != 7 || n_rel != 0) begin
      n_errors++;
      $display("FAIL mid_reset_repress: got press0@%0d press2@%0d releases=%0d expected 7 7 0",
               p0, p2, n_rel);
    end
    btn = 3'b000;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int remain [W];
    for (int i = 0; i < W; i++) remain[i] = 0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({level, press, release_pulse, long_press} !== {m_level, m_press, m_rel, m_long}) begin
        n_errors++;
        $display("FAIL random k=%0d: got %b expected %b", k,
                 {level, press, release_pulse, long_press}, {m_level, m_press, m_rel, m_long});
      end
      for (int i = 0; i < W; i++) begin
        if (remain[i] == 0) begin
          btn[i]    = $urandom_range(0, 1) != 0;
          remain[i] = $urandom_range(1, 30);
        end else begin
          remain[i]--;
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    btn    = '0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_press();
    test_release_bounce();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
